// File: rtl/proj_lif_scheduler_pkg.sv
// Shared hyper-parameters and FSM encoding for the projection LIF scheduler.
//   DefAdd9AllBits : membrane/delta width (signed)
//   DefNeurons     : neurons per timestep
//   DefTimesteps   : timesteps per run
//   sched_state_e  : scheduler FSM state encoding
package proj_lif_scheduler_pkg;

    localparam int DefAdd9AllBits = 16;
    localparam int DefNeurons     = 64;
    localparam int DefTimesteps   = 4;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StClear = 3'd1,
        StRun   = 3'd2,
        StDrain = 3'd3,
        StDone  = 3'd4
    } sched_state_e;

endpackage

// File: rtl/proj_lif_mem_ram.sv
// Single-clock simple dual-port RAM with 1-cycle synchronous read.
//   s_clk, s_rst      : clock, async active-high reset (read register only)
//   i_we/i_waddr/i_wdata : write port
//   i_re/i_raddr      : read port request
//   o_rdata           : read data, valid the cycle after i_re
module proj_lif_mem_ram #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             s_clk,
    input  logic             s_rst,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_re,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Array is left unreset so it maps onto block RAM.
    always_ff @(posedge s_clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            o_rdata <= '0;
        end else if (i_re) begin
            o_rdata <= mem_q[i_raddr];
        end
    end

endmodule

// File: rtl/proj_lif_scheduler.sv
// Sequencer for the projection LIF datapath. Owns the membrane memory, pairs each
// upstream delta with the stored membrane, sends both to an external proj_lif,
// writes the returned next membrane back and emits indexed spike events.
//   s_clk, s_rst                  : clock, async active-high reset
//   i_start, i_threshold          : run start pulse, threshold latched on start
//   i_delta, i_delta_valid, o_delta_ready : upstream delta handshake
//   o_lif_*                       : inputs to the external LIF datapath
//   i_lif_spike/valid/nxt_mem     : LIF results, one cycle after o_lif_delta_valid
//   o_spike_valid/o_spike/o_spike_idx/o_spike_t : spike events
//   o_busy, o_done                : status
module proj_lif_scheduler
    import proj_lif_scheduler_pkg::*;
#(
    parameter int ADD9_ALL_BITS = DefAdd9AllBits,
    parameter int NEURONS       = DefNeurons,
    parameter int TIMESTEPS     = DefTimesteps,
    parameter int IDX_W         = $clog2(NEURONS),
    parameter int T_W           = (TIMESTEPS > 1) ? $clog2(TIMESTEPS) : 1
) (
    input  logic                            s_clk,
    input  logic                            s_rst,
    input  logic                            i_start,
    input  logic signed [ADD9_ALL_BITS-1:0] i_threshold,
    input  logic signed [ADD9_ALL_BITS-1:0] i_delta,
    input  logic                            i_delta_valid,
    output logic                            o_delta_ready,
    output logic signed [ADD9_ALL_BITS-1:0] o_lif_threshold,
    output logic signed [ADD9_ALL_BITS-1:0] o_lif_delta,
    output logic                            o_lif_delta_valid,
    output logic signed [ADD9_ALL_BITS-1:0] o_lif_pre_mem,
    input  logic                            i_lif_spike,
    input  logic                            i_lif_valid,
    input  logic signed [ADD9_ALL_BITS-1:0] i_lif_nxt_mem,
    output logic                            o_spike_valid,
    output logic                            o_spike,
    output logic [IDX_W-1:0]                o_spike_idx,
    output logic [T_W-1:0]                  o_spike_t,
    output logic                            o_busy,
    output logic                            o_done
);

    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NEURONS - 1);
    localparam logic [T_W-1:0]   LastT   = T_W'(TIMESTEPS - 1);

    sched_state_e                    state_q;
    logic signed [ADD9_ALL_BITS-1:0] thr_q;
    logic [IDX_W-1:0]                clr_idx_q;
    logic [IDX_W-1:0]                n_q;
    logic [T_W-1:0]                  t_q;
    logic                            drain_cnt_q;

    // Beat pipeline: stage 1 faces the LIF input, stage 2 meets the LIF result.
    logic                            s1_valid_q, s2_valid_q;
    logic signed [ADD9_ALL_BITS-1:0] s1_delta_q;
    logic [IDX_W-1:0]                s1_idx_q, s2_idx_q;
    logic [T_W-1:0]                  s1_t_q, s2_t_q;

    logic                     accept;
    logic                     wb;
    logic                     ram_we;
    logic [IDX_W-1:0]         ram_waddr;
    logic [ADD9_ALL_BITS-1:0] ram_wdata;
    logic [ADD9_ALL_BITS-1:0] ram_rdata;

    assign accept = o_delta_ready & i_delta_valid;
    // Stale LIF output after a mid-run reset is masked by s2_valid_q.
    assign wb     = s2_valid_q & i_lif_valid;

    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            state_q       <= StIdle;
            thr_q         <= '0;
            clr_idx_q     <= '0;
            n_q           <= '0;
            t_q           <= '0;
            drain_cnt_q   <= 1'b0;
            o_delta_ready <= 1'b0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (i_start) begin
                        state_q   <= StClear;
                        thr_q     <= i_threshold;
                        clr_idx_q <= '0;
                        o_busy    <= 1'b1;
                    end
                end
                StClear: begin
                    clr_idx_q <= clr_idx_q + 1'b1;
                    if (clr_idx_q == LastIdx) begin
                        state_q       <= StRun;
                        n_q           <= '0;
                        t_q           <= '0;
                        o_delta_ready <= 1'b1;
                    end
                end
                StRun: begin
                    if (accept) begin
                        if (n_q == LastIdx) begin
                            n_q <= '0;
                            if (t_q == LastT) begin
                                state_q       <= StDrain;
                                drain_cnt_q   <= 1'b0;
                                o_delta_ready <= 1'b0;
                            end else begin
                                t_q <= t_q + 1'b1;
                            end
                        end else begin
                            n_q <= n_q + 1'b1;
                        end
                    end
                end
                StDrain: begin
                    // Two cycles cover the last beat's LIF pass and writeback.
                    drain_cnt_q <= 1'b1;
                    if (drain_cnt_q) begin
                        state_q <= StDone;
                        o_done  <= 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    o_busy  <= 1'b0;
                end
                default: begin
                    state_q       <= StIdle;
                    o_delta_ready <= 1'b0;
                    o_busy        <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            s1_valid_q <= 1'b0;
            s1_delta_q <= '0;
            s1_idx_q   <= '0;
            s1_t_q     <= '0;
            s2_valid_q <= 1'b0;
            s2_idx_q   <= '0;
            s2_t_q     <= '0;
        end else begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_delta_q <= i_delta;
                s1_idx_q   <= n_q;
                s1_t_q     <= t_q;
            end
            s2_valid_q <= s1_valid_q;
            s2_idx_q   <= s1_idx_q;
            s2_t_q     <= s1_t_q;
        end
    end

    // CLEAR owns the write port; no beats are in flight while it runs.
    always_comb begin
        ram_we    = wb;
        ram_waddr = s2_idx_q;
        ram_wdata = i_lif_nxt_mem;
        if (state_q == StClear) begin
            ram_we    = 1'b1;
            ram_waddr = clr_idx_q;
            ram_wdata = '0;
        end
    end

    proj_lif_mem_ram #(
        .DEPTH (NEURONS),
        .WIDTH (ADD9_ALL_BITS),
        .AW    (IDX_W)
    ) u_mem (
        .s_clk   (s_clk),
        .s_rst   (s_rst),
        .i_we    (ram_we),
        .i_waddr (ram_waddr),
        .i_wdata (ram_wdata),
        .i_re    (accept),
        .i_raddr (n_q),
        .o_rdata (ram_rdata)
    );

    assign o_lif_threshold   = thr_q;
    assign o_lif_delta       = s1_delta_q;
    assign o_lif_delta_valid = s1_valid_q;
    assign o_lif_pre_mem     = ram_rdata;
    assign o_spike_valid     = wb;
    assign o_spike           = wb & i_lif_spike;
    assign o_spike_idx       = s2_idx_q;
    assign o_spike_t         = s2_t_q;

endmodule

// File: tb/tb_proj_lif_scheduler.sv
module tb_proj_lif_scheduler;

    localparam int N  = 4;
    localparam int T  = 4;
    localparam int NT = N * T;
    localparam int W  = 16;

    logic                s_clk = 1'b0;
    logic                s_rst = 1'b1;
    logic                i_start = 1'b0;
    logic signed [W-1:0] i_threshold = '0;
    logic signed [W-1:0] i_delta = '0;
    logic                i_delta_valid = 1'b0;
    logic                o_delta_ready;
    logic signed [W-1:0] o_lif_threshold, o_lif_delta, o_lif_pre_mem;
    logic                o_lif_delta_valid;
    logic                i_lif_spike, i_lif_valid;
    logic signed [W-1:0] i_lif_nxt_mem;
    logic                o_spike_valid, o_spike, o_busy, o_done;
    logic [1:0]          o_spike_idx, o_spike_t;

    proj_lif_scheduler #(
        .ADD9_ALL_BITS (W),
        .NEURONS       (N),
        .TIMESTEPS     (T)
    ) dut (
        .s_clk             (s_clk),
        .s_rst             (s_rst),
        .i_start           (i_start),
        .i_threshold       (i_threshold),
        .i_delta           (i_delta),
        .i_delta_valid     (i_delta_valid),
        .o_delta_ready     (o_delta_ready),
        .o_lif_threshold   (o_lif_threshold),
        .o_lif_delta       (o_lif_delta),
        .o_lif_delta_valid (o_lif_delta_valid),
        .o_lif_pre_mem     (o_lif_pre_mem),
        .i_lif_spike       (i_lif_spike),
        .i_lif_valid       (i_lif_valid),
        .i_lif_nxt_mem     (i_lif_nxt_mem),
        .o_spike_valid     (o_spike_valid),
        .o_spike           (o_spike),
        .o_spike_idx       (o_spike_idx),
        .o_spike_t         (o_spike_t),
        .o_busy            (o_busy),
        .o_done            (o_done)
    );

    always #5 s_clk = ~s_clk;

    int cyc = 0;
    always @(posedge s_clk) cyc <= cyc + 1;

    // Stand-in for the external proj_lif: leaky average, fire and reset to 0.
    always @(posedge s_clk or posedge s_rst) begin : lif_model
        int v;
        if (s_rst) begin
            i_lif_valid   <= 1'b0;
            i_lif_spike   <= 1'b0;
            i_lif_nxt_mem <= '0;
        end else begin
            v = (int'(o_lif_pre_mem) + int'(o_lif_delta)) >>> 1;
            i_lif_valid   <= o_lif_delta_valid;
            i_lif_spike   <= (v >= int'(o_lif_threshold));
            i_lif_nxt_mem <= (v >= int'(o_lif_threshold)) ? W'(0) : W'(v);
        end
    end

    int checks = 0;
    int failures = 0;

    // Observed streams
    int obs_pre[$], obs_dl[$], obs_sp[$], obs_idx[$], obs_t[$], obs_nxt[$], obs_ecyc[$];
    int acc_q[$];
    int done_cnt, done_cyc;

    always @(negedge s_clk) begin
        if (!s_rst) begin
            if (o_lif_delta_valid) begin
                obs_pre.push_back(int'(o_lif_pre_mem));
                obs_dl.push_back(int'(o_lif_delta));
            end
            if (o_spike_valid) begin
                obs_sp.push_back(int'(o_spike));
                obs_idx.push_back(int'(o_spike_idx));
                obs_t.push_back(int'(o_spike_t));
                obs_nxt.push_back(int'(i_lif_nxt_mem));
                obs_ecyc.push_back(cyc);
            end
            if (o_done) begin
                done_cnt = done_cnt + 1;
                done_cyc = cyc;
            end
        end
    end

    // Reference model
    int dl[NT];
    int exp_pre[NT], exp_sp[NT];
    int start_cyc, rdy_cyc;

    function automatic void build_exp(input int thr);
        int mem[N];
        int v;
        foreach (mem[i]) mem[i] = 0;
        for (int t = 0; t < T; t++) begin
            for (int n = 0; n < N; n++) begin
                exp_pre[t*N+n] = mem[n];
                v = (mem[n] + dl[t*N+n]) / 2;
                exp_sp[t*N+n] = (v >= thr) ? 1 : 0;
                mem[n] = (v >= thr) ? 0 : v;
            end
        end
    endfunction

    // Number of beats whose data, index, timestep or 2-cycle latency disagree.
    function automatic int run_diffs();
        int d = 0;
        if (obs_pre.size() != NT || obs_sp.size() != NT || acc_q.size() != NT) return 1000;
        for (int k = 0; k < NT; k++) begin
            if (obs_pre[k] != exp_pre[k]) d++;
            if (obs_dl[k] != dl[k]) d++;
            if (obs_sp[k] != exp_sp[k]) d++;
            if (obs_idx[k] != k % N) d++;
            if (obs_t[k] != k / N) d++;
            if (obs_ecyc[k] - acc_q[k] != 2) d++;
        end
        return d;
    endfunction

    task automatic do_run(input int thr, input bit gaps, input bit poke, input int stop_at);
        int  k;
        int  g;
        bit  v;
        obs_pre.delete(); obs_dl.delete(); obs_sp.delete(); obs_idx.delete();
        obs_t.delete(); obs_nxt.delete(); obs_ecyc.delete(); acc_q.delete();
        done_cnt = 0;
        done_cyc = 0;
        @(posedge s_clk); #1;
        i_start = 1'b1;
        i_threshold = W'(thr);
        start_cyc = cyc;
        @(posedge s_clk); #1;
        i_start = 1'b0;
        g = 0;
        while (!o_delta_ready && g < 200) begin
            @(posedge s_clk); #1;
            g++;
        end
        rdy_cyc = cyc;
        checks++;
        if (!o_delta_ready) begin
            failures++;
            $display("FAIL ready_timeout: o_delta_ready=%0b required=1", o_delta_ready);
            return;
        end
        k = 0;
        g = 0;
        while (k < stop_at && g < 4000) begin
            v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            i_delta_valid = v;
            i_delta = W'(dl[k]);
            if (poke && k == 5) begin
                i_start = 1'b1;
                i_threshold = W'(7);
            end
            if (v && o_delta_ready) begin
                acc_q.push_back(cyc);
                k++;
            end
            @(posedge s_clk); #1;
            i_start = 1'b0;
            g++;
        end
        i_delta_valid = 1'b0;
        checks++;
        if (k != stop_at) begin
            failures++;
            $display("FAIL accept_timeout: accepted=%0d required=%0d", k, stop_at);
            return;
        end
        if (stop_at != NT) return;
        if (poke) begin
            i_start = 1'b1;
            @(posedge s_clk); #1;
            i_start = 1'b0;
        end
        g = 0;
        while (done_cnt == 0 && g < 40) begin
            @(posedge s_clk); #1;
            g++;
        end
        checks++;
        if (done_cnt == 0) begin
            failures++;
            $display("FAIL done_timeout: done_cnt=%0d required>=1", done_cnt);
        end
        repeat (4) @(posedge s_clk);
        #1;
    endtask

    task automatic test_reset();
        s_rst = 1'b1;
        repeat (3) @(posedge s_clk);
        #1;
        checks++;
        if ({o_delta_ready, o_lif_delta_valid, o_spike_valid, o_spike, o_busy, o_done} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got=%b required=000000",
                     {o_delta_ready, o_lif_delta_valid, o_spike_valid, o_spike, o_busy, o_done});
        end
        checks++;
        if ({o_lif_threshold, o_lif_delta, o_lif_pre_mem, o_spike_idx, o_spike_t} !== '0) begin
            failures++;
            $display("FAIL reset_data: thr=%0d delta=%0d pre=%0d idx=%0d t=%0d required=all 0",
                     o_lif_threshold, o_lif_delta, o_lif_pre_mem, o_spike_idx, o_spike_t);
        end
        s_rst = 1'b0;
        repeat (2) @(posedge s_clk);
        #1;
        checks++;
        if (o_busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_busy: o_busy=%b required=0", o_busy);
        end
    endtask

    task automatic test_const100();
        int d;
        int sc;
        int exp_pre0[4] = '{0, 50, 75, 87};
        int exp_nxt0[4] = '{50, 75, 87, 93};
        foreach (dl[k]) dl[k] = 100;
        build_exp(100);
        do_run(100, 1'b0, 1'b0, NT);
        d = run_diffs();
        checks++;
        if (d != 0) begin
            failures++;
            $display("FAIL c100_stream: diffs=%0d required=0", d);
        end
        sc = 0;
        foreach (obs_sp[k]) sc += obs_sp[k];
        checks++;
        if (sc != 0 || obs_sp.size() != NT) begin
            failures++;
            $display("FAIL c100_events: spikes=%0d events=%0d required 0/%0d", sc, obs_sp.size(), NT);
        end
        for (int t = 0; t < T; t++) begin
            checks++;
            if (obs_pre.size() != NT || obs_nxt.size() != NT ||
                obs_pre[t*N] != exp_pre0[t] || obs_nxt[t*N] != exp_nxt0[t]) begin
                failures++;
                $display("FAIL c100_n0_mem t=%0d: pre=%0d nxt=%0d required pre=%0d nxt=%0d", t,
                         (obs_pre.size() > t*N) ? obs_pre[t*N] : -1,
                         (obs_nxt.size() > t*N) ? obs_nxt[t*N] : -1, exp_pre0[t], exp_nxt0[t]);
            end
        end
        checks++;
        if (rdy_cyc - start_cyc != N + 1) begin
            failures++;
            $display("FAIL start_to_ready: got=%0d required=%0d", rdy_cyc - start_cyc, N + 1);
        end
        checks++;
        if (acc_q.size() != NT || done_cyc - acc_q[NT-1] != 3) begin
            failures++;
            $display("FAIL last_accept_to_done: done_cyc=%0d required 3 after last accept", done_cyc);
        end
        checks++;
        if (done_cyc - start_cyc + 1 != N * (T + 1) + 4) begin
            failures++;
            $display("FAIL run_length: got=%0d required=%0d", done_cyc - start_cyc + 1,
                     N * (T + 1) + 4);
        end
        checks++;
        if (done_cnt != 1 || o_busy !== 1'b0 || o_lif_threshold !== W'(100)) begin
            failures++;
            $display("FAIL c100_end: done_cnt=%0d busy=%b thr=%0d required 1/0/100",
                     done_cnt, o_busy, o_lif_threshold);
        end
    endtask

    task automatic test_spike180();
        int d;
        int sc;
        int bad;
        foreach (dl[k]) dl[k] = 180;
        build_exp(100);
        do_run(100, 1'b0, 1'b0, NT);
        d = run_diffs();
        checks++;
        if (d != 0) begin
            failures++;
            $display("FAIL s180_stream: diffs=%0d required=0", d);
        end
        sc = 0;
        bad = 0;
        foreach (obs_sp[k]) begin
            sc += obs_sp[k];
            if (obs_sp[k] != obs_t[k] % 2) bad++;
        end
        checks++;
        if (sc != 8 || bad != 0) begin
            failures++;
            $display("FAIL s180_pattern: spikes=%0d misplaced=%0d required 8/0", sc, bad);
        end
        checks++;
        if (obs_nxt.size() != NT || obs_nxt[0] != 90 || obs_nxt[4] != 0 ||
            obs_nxt[8] != 90 || obs_nxt[12] != 0) begin
            failures++;
            $display("FAIL s180_n0_mem: size=%0d required sequence 90,0,90,0", obs_nxt.size());
        end
    endtask

    task automatic test_single_neuron();
        int d;
        int s2;
        int so;
        foreach (dl[k]) dl[k] = (k % N == 2) ? 300 : 0;
        build_exp(100);
        do_run(100, 1'b0, 1'b0, NT);
        d = run_diffs();
        checks++;
        if (d != 0) begin
            failures++;
            $display("FAIL n2_stream: diffs=%0d required=0", d);
        end
        s2 = 0;
        so = 0;
        foreach (obs_sp[k]) begin
            if (obs_idx[k] == 2) s2 += obs_sp[k];
            else so += obs_sp[k];
        end
        checks++;
        if (s2 != T || so != 0) begin
            failures++;
            $display("FAIL n2_spikes: n2=%0d others=%0d required %0d/0", s2, so, T);
        end
    endtask

    task automatic test_gaps();
        int d;
        foreach (dl[k]) dl[k] = 100;
        build_exp(100);
        do_run(100, 1'b1, 1'b0, NT);
        d = run_diffs();
        checks++;
        if (d != 0) begin
            failures++;
            $display("FAIL gaps_stream: diffs=%0d required=0", d);
        end
        checks++;
        if (done_cnt != 1 || acc_q.size() != NT || done_cyc - acc_q[NT-1] != 3) begin
            failures++;
            $display("FAIL gaps_done: done_cnt=%0d done_cyc=%0d required one done 3 after last",
                     done_cnt, done_cyc);
        end
    endtask

    task automatic test_random();
        int d;
        int thr;
        for (int r = 0; r < 3; r++) begin
            thr = int'($urandom_range(60, 200));
            foreach (dl[k]) dl[k] = int'($urandom_range(0, 300));
            build_exp(thr);
            do_run(thr, 1'b1, 1'b0, NT);
            d = run_diffs();
            checks++;
            if (d != 0) begin
                failures++;
                $display("FAIL rand_stream r=%0d thr=%0d: diffs=%0d required=0", r, thr, d);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        int d;
        foreach (dl[k]) dl[k] = 180;
        do_run(100, 1'b0, 1'b0, 7);
        s_rst = 1'b1;
        #2;
        checks++;
        if ({o_delta_ready, o_lif_delta_valid, o_spike_valid, o_busy} !== 4'b0) begin
            failures++;
            $display("FAIL midrst_ctrl: got=%b required=0000",
                     {o_delta_ready, o_lif_delta_valid, o_spike_valid, o_busy});
        end
        s_rst = 1'b0;
        repeat (2) @(posedge s_clk);
        #1;
        foreach (dl[k]) dl[k] = 100;
        build_exp(100);
        do_run(100, 1'b0, 1'b0, NT);
        d = run_diffs();
        checks++;
        if (d != 0 || obs_nxt.size() != NT || obs_nxt[0] != 50 || obs_nxt[4] != 75 ||
            obs_nxt[8] != 87 || obs_nxt[12] != 93) begin
            failures++;
            $display("FAIL midrst_rerun: diffs=%0d events=%0d required 0 diffs, n0 50,75,87,93",
                     d, obs_nxt.size());
        end
    endtask

    task automatic test_start_ignored();
        int d;
        foreach (dl[k]) dl[k] = 180;
        build_exp(100);
        do_run(100, 1'b0, 1'b1, NT);
        d = run_diffs();
        checks++;
        if (d != 0) begin
            failures++;
            $display("FAIL poke_stream: diffs=%0d required=0", d);
        end
        repeat (NT + 2 * N) @(posedge s_clk);
        #1;
        checks++;
        if (done_cnt != 1 || o_busy !== 1'b0 || o_lif_threshold !== W'(100)) begin
            failures++;
            $display("FAIL poke_done: done_cnt=%0d busy=%b thr=%0d required 1/0/100",
                     done_cnt, o_busy, o_lif_threshold);
        end
    endtask

    initial begin
        test_reset();
        test_const100();
        test_spike180();
        test_single_neuron();
        test_gaps();
        test_random();
        test_reset_mid_run();
        test_start_ignored();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
